// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types for the receive and transmit paths
package uart_pkg;

    localparam int FRAME_W = 11;

    typedef enum logic [1:0] {
        P_NONE = 2'b00,
        P_EVEN = 2'b01,
        P_ODD  = 2'b10,
        P_RSVD = 2'b11
    } parity_t;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_PUSH  = 2'b10
    } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous FIFO of rx_entry_t with wrap-bit pointers
module rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_i,
    input  rx_entry_t       wr_data_i,
    input  logic            rd_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o,
    output rx_entry_t       head_o
);

    rx_entry_t       mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_wr, do_rd;

    // A write into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_rd    = rd_i && !empty_o;
        do_wr    = wr_i && (!full_o || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_o  = CW'(wr_ptr_q - rd_ptr_q);
        head_o   = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; wrap is plain modulo arithmetic on AW+1 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since empty pointers mask stale contents.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/rx_controller.sv
// rtl/rx_controller.sv - UART receive frame decode, check and buffering
module rx_controller
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cr_ds_i,
    input  logic [1:0]          cr_p_i,
    input  logic                cr_s_i,
    input  logic [FRAME_W-1:0]  frame_i,
    input  logic                frame_valid_i,
    input  logic                rx_read_i,
    input  logic                ore_clear_i,
    output logic [7:0]          rx_data_o,
    output logic                rx_pe_o,
    output logic                rx_fe_o,
    output logic                rx_ne_o,
    output logic                rx_full_o,
    output logic [CW-1:0]       rx_count_o,
    output logic                rx_ore_o
);

    rx_state_t            state_q, state_d;
    logic [FRAME_W-1:0]   frame_q;
    logic                 ds_q, stop2_q;
    parity_t              par_q;
    rx_entry_t            entry_q, dec;
    logic                 capture, do_check, push;
    logic                 par_en;
    logic [3:0]           par_idx, stop_idx;
    logic                 ore_q, ore_d, ore_set;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;
    rx_entry_t            fifo_head;
    rx_entry_t            head_q;
    logic                 ne_q, full_q;
    logic [CW-1:0]        count_q;

    // FSM state register; reset abandons any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: one cycle each to decode and to push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_valid_i) state_d = S_CHECK;
            S_CHECK: state_d = S_PUSH;
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: capture, check and push strobes.
    always_comb begin
        capture  = (state_q == S_IDLE) && frame_valid_i;
        do_check = (state_q == S_CHECK);
        push     = (state_q == S_PUSH);
    end

    // Frame and configuration are frozen at capture so later cr_* writes cannot corrupt this frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q <= '0;
            ds_q    <= 1'b0;
            par_q   <= P_NONE;
            stop2_q <= 1'b0;
        end else if (capture) begin
            frame_q <= frame_i;
            ds_q    <= cr_ds_i;
            par_q   <= parity_t'(cr_p_i);
            stop2_q <= cr_s_i;
        end
    end

    // Decode: parity sits right after the data bits, stop bits right after parity (or data).
    always_comb begin
        par_en    = (par_q == P_EVEN) || (par_q == P_ODD);
        par_idx   = ds_q ? 4'd8 : 4'd7;
        stop_idx  = par_idx + {3'b000, par_en};
        dec.data  = {ds_q & frame_q[7], frame_q[6:0]};
        dec.pe    = par_en && ((^dec.data ^ frame_q[par_idx]) != (par_q == P_ODD));
        dec.fe    = !frame_q[stop_idx] || (stop2_q && !frame_q[stop_idx + 4'd1]);
    end

    // Check result register feeding the FIFO write in PUSH.
    always_ff @(posedge clk_i) begin
        if (rst_i)         entry_q <= '0;
        else if (do_check) entry_q <= dec;
    end

    rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (push),
        .wr_data_i (entry_q),
        .rd_i      (rx_read_i),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .head_o    (fifo_head)
    );

    // Overrun: full push without a coincident pop, or a frame arriving while busy; set beats clear.
    always_comb begin
        ore_set = (push && fifo_full && !rx_read_i) || (frame_valid_i && (state_q != S_IDLE));
        ore_d   = ore_set ? 1'b1 : (ore_clear_i ? 1'b0 : ore_q);
    end

    // Sticky overrun register.
    always_ff @(posedge clk_i) begin
        if (rst_i) ore_q <= 1'b0;
        else       ore_q <= ore_d;
    end

    // Registered status and head; head holds its last value once the FIFO drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            ne_q    <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (!fifo_empty) head_q <= fifo_head;
            ne_q    <= !fifo_empty;
            full_q  <= fifo_full;
            count_q <= fifo_count;
        end
    end

    assign rx_data_o  = head_q.data;
    assign rx_pe_o    = head_q.pe;
    assign rx_fe_o    = head_q.fe;
    assign rx_ne_o    = ne_q;
    assign rx_full_o  = full_q;
    assign rx_count_o = count_q;
    assign rx_ore_o   = ore_q;

endmodule

// File: tb/tb_rx_controller.sv
// tb/tb_rx_controller.sv - self-checking bench for rx_controller
module tb_rx_controller;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cr_ds = 1'b0;
    logic [1:0]  cr_p = 2'b00;
    logic        cr_s = 1'b0;
    logic [10:0] frame = '0;
    logic        frame_valid = 1'b0;
    logic        rx_read = 1'b0;
    logic        ore_clear = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_pe, rx_fe, rx_ne, rx_full, rx_ore;
    logic [2:0]  rx_count;

    int checks = 0;
    int errors = 0;

    logic [9:0]  mq[$];
    logic        m_ore = 1'b0;
    logic [9:0]  m_head = '0;

    always #5 clk = ~clk;

    rx_controller #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cr_ds_i       (cr_ds),
        .cr_p_i        (cr_p),
        .cr_s_i        (cr_s),
        .frame_i       (frame),
        .frame_valid_i (frame_valid),
        .rx_read_i     (rx_read),
        .ore_clear_i   (ore_clear),
        .rx_data_o     (rx_data),
        .rx_pe_o       (rx_pe),
        .rx_fe_o       (rx_fe),
        .rx_ne_o       (rx_ne),
        .rx_full_o     (rx_full),
        .rx_count_o    (rx_count),
        .rx_ore_o      (rx_ore)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: walk the frame bit positions in order (data, parity, stop).
    function automatic logic [9:0] ref_decode(input logic [10:0] f, input logic ds,
                                              input logic [1:0] p, input logic s);
        int nd = ds ? 8 : 7;
        int pos;
        int ones = 0;
        logic [7:0] d = '0;
        logic pe = 1'b0;
        logic fe = 1'b0;
        for (int i = 0; i < nd; i++) begin
            d[i] = f[i];
            ones += int'(f[i]);
        end
        pos = nd;
        if (p == 2'b01 || p == 2'b10) begin
            ones += int'(f[pos]);
            pe = (p == 2'b01) ? (ones % 2 != 0) : (ones % 2 == 0);
            pos++;
        end
        for (int k = 0; k < (s ? 2 : 1); k++) begin
            if (!f[pos]) fe = 1'b1;
            pos++;
        end
        return {fe, pe, d};
    endfunction

    task automatic check_all(input string ctx);
        if (mq.size() > 0) m_head = mq[0];
        chk({ctx, ".ne"},    rx_ne,    (mq.size() > 0));
        chk({ctx, ".full"},  rx_full,  (mq.size() == DEPTH));
        chk({ctx, ".count"}, rx_count, mq.size());
        chk({ctx, ".ore"},   rx_ore,   m_ore);
        chk({ctx, ".data"},  rx_data,  m_head[7:0]);
        chk({ctx, ".pe"},    rx_pe,    m_head[8]);
        chk({ctx, ".fe"},    rx_fe,    m_head[9]);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    // One-cycle frame pulse; optional pop timed to coincide with the PUSH cycle.
    task automatic send(input logic [10:0] f, input logic ds, input logic [1:0] p,
                        input logic s, input logic rd_at_push);
        logic [9:0] e;
        @(negedge clk);
        frame = f; cr_ds = ds; cr_p = p; cr_s = s; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        frame = 11'($urandom);
        cr_ds = 1'($urandom); cr_p = 2'($urandom); cr_s = 1'($urandom);
        if (rd_at_push) begin
            @(negedge clk); rx_read = 1'b1;
            @(negedge clk); rx_read = 1'b0;
        end
        e = ref_decode(f, ds, p, s);
        if (rd_at_push && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ore = 1'b1;
    endtask

    task automatic pop();
        @(negedge clk); rx_read = 1'b1;
        @(negedge clk); rx_read = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        settle();
    endtask

    task automatic clear_ore();
        @(negedge clk); ore_clear = 1'b1;
        @(negedge clk); ore_clear = 1'b0;
        m_ore = 1'b0;
        settle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset");

        // 8N1 frame and its exact latency
        send(11'h155, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("lat.ne_early", rx_ne, 1'b0);
        @(negedge clk);
        chk("lat.ne_on_time", rx_ne, 1'b1);
        chk("lat.data", rx_data, 8'h55);
        settle();
        check_all("t1");
        pop();

        // even parity, good then bad
        send(11'h203, 1'b1, 2'b01, 1'b0, 1'b0); settle(); check_all("t2a");
        pop();
        send(11'h303, 1'b1, 2'b01, 1'b0, 1'b0); settle(); check_all("t2b");
        chk("t2b.pe_const", rx_pe, 1'b1);
        pop();

        // 7O2 good, then framing error
        send(11'h3C1, 1'b0, 2'b10, 1'b1, 1'b0); settle(); check_all("t3a");
        chk("t3a.data_const", rx_data, 8'h41);
        pop();
        send(11'h1C1, 1'b0, 2'b10, 1'b1, 1'b0); settle(); check_all("t3b");
        chk("t3b.fe_const", rx_fe, 1'b1);
        pop();

        // overfill by one
        for (int i = 1; i <= 5; i++) begin
            send(11'h100 | 11'(i), 1'b1, 2'b00, 1'b0, 1'b0);
            settle();
        end
        check_all("t4.full");
        chk("t4.ore_const", rx_ore, 1'b1);
        clear_ore();
        check_all("t4.cleared");
        for (int i = 0; i < 4; i++) begin
            pop();
            check_all("t4.drain");
        end

        // full with pop coincident with push
        for (int i = 0; i < 4; i++) begin
            send(11'h100 | 11'(8'h10 + i), 1'b1, 2'b00, 1'b0, 1'b0);
            settle();
        end
        send(11'h1AA, 1'b1, 2'b00, 1'b0, 1'b1); settle();
        check_all("t5.coincident");
        for (int i = 0; i < 4; i++) begin
            pop();
            check_all("t5.drain");
        end

        // frame arriving while busy is dropped and flags overrun
        @(negedge clk);
        frame = 11'h177; cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0; frame_valid = 1'b1;
        @(negedge clk);
        frame = 11'h188;
        @(negedge clk);
        frame_valid = 1'b0;
        mq.push_back(ref_decode(11'h177, 1'b1, 2'b00, 1'b0));
        m_ore = 1'b1;
        settle();
        check_all("busy");
        pop();
        clear_ore();

        // reset the cycle after capture
        send(11'h1F0, 1'b1, 2'b00, 1'b0, 1'b0);
        send(11'h1F1, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        frame = 11'h1F2; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_ore = 1'b0; m_head = '0;
        @(negedge clk);
        check_all("t6.reset");
        send(11'h1C3, 1'b1, 2'b00, 1'b0, 1'b0); settle();
        check_all("t6.after");
        pop();

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int op = $urandom_range(0, 9);
            if (op < 6) begin
                send(11'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), (op == 5));
                settle();
            end else if (op < 9) begin
                pop();
            end else begin
                clear_ore();
            end
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
